// File: rtl/axil_protocol_monitor.sv
// Passive AXI4-Lite bus monitor: payload stability, outstanding-count and stall-timeout checks.
// Detected errors appear in sticky err_flags/irq one cycle later. The monitor never drives the bus.
module axil_protocol_monitor #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  input  logic                       s_axi_awready,
  input  logic [DATA_W-1:0]          s_axi_wdata,
  input  logic [DATA_W/8-1:0]        s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  input  logic                       s_axi_wready,
  input  logic [1:0]                 s_axi_bresp,
  input  logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic                       s_axi_arvalid,
  input  logic                       s_axi_arready,
  input  logic [DATA_W-1:0]          s_axi_rdata,
  input  logic [1:0]                 s_axi_rresp,
  input  logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic                       err_clear,
  output logic [7:0]                 err_flags,
  output logic [2:0]                 err_first,
  output logic                       err_first_vld,
  output logic                       irq,
  output logic [$clog2(MAX_OUT+1)-1:0] wr_out,
  output logic [$clog2(MAX_OUT+1)-1:0] rd_out
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CW     = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
  localparam logic [15:0]   TO_C  = 16'(TIMEOUT);

  // Channel order: 0 AW, 1 W, 2 B, 3 AR, 4 R
  logic [4:0] vld, rdy, stall, hs, changed, stab_err, to_hit;
  logic [4:0] stalled_q;

  logic [ADDR_W-1:0]        aw_q, ar_q;
  logic [DATA_W+STRB_W-1:0] w_q;
  logic [1:0]               b_q;
  logic [DATA_W+1:0]        r_q;
  logic [15:0]              stall_cnt [5];

  assign vld   = {s_axi_rvalid, s_axi_arvalid, s_axi_bvalid, s_axi_wvalid, s_axi_awvalid};
  assign rdy   = {s_axi_rready, s_axi_arready, s_axi_bready, s_axi_wready, s_axi_awready};
  assign stall = vld & ~rdy;
  assign hs    = vld & rdy;

  assign changed[0] = (s_axi_awaddr != aw_q);
  assign changed[1] = ({s_axi_wdata, s_axi_wstrb} != w_q);
  assign changed[2] = (s_axi_bresp != b_q);
  assign changed[3] = (s_axi_araddr != ar_q);
  assign changed[4] = ({s_axi_rdata, s_axi_rresp} != r_q);

  assign stab_err = stalled_q & (~vld | changed);

  // Timeout fires on the edge where a counter reaches TIMEOUT, not while it sits saturated.
  always_comb begin
    to_hit = '0;
    for (int i = 0; i < 5; i++) begin
      to_hit[i] = stall[i] && (stall_cnt[i] == TO_C - 16'd1);
    end
  end

  logic wr_inc, wr_dec, rd_inc, rd_dec, wr_err, rd_err;
  assign wr_inc = hs[0] & ~hs[2];
  assign wr_dec = hs[2] & ~hs[0];
  assign rd_inc = hs[3] & ~hs[4];
  assign rd_dec = hs[4] & ~hs[3];
  assign wr_err = (wr_inc && wr_out == MAX_C) || (wr_dec && wr_out == '0);
  assign rd_err = (rd_inc && rd_out == MAX_C) || (rd_dec && rd_out == '0);

  logic [7:0] err_new, flags_nxt;
  assign err_new   = {|to_hit, rd_err, wr_err, stab_err};
  assign flags_nxt = err_clear ? err_new : (err_flags | err_new);

  function automatic logic [2:0] lowest(input logic [7:0] v);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      stalled_q <= '0;
      aw_q      <= '0;
      w_q       <= '0;
      b_q       <= '0;
      ar_q      <= '0;
      r_q       <= '0;
      for (int i = 0; i < 5; i++) stall_cnt[i] <= '0;
    end else begin
      stalled_q <= stall;
      aw_q      <= s_axi_awaddr;
      w_q       <= {s_axi_wdata, s_axi_wstrb};
      b_q       <= s_axi_bresp;
      ar_q      <= s_axi_araddr;
      r_q       <= {s_axi_rdata, s_axi_rresp};
      for (int i = 0; i < 5; i++) begin
        if (!stall[i])                stall_cnt[i] <= '0;
        else if (stall_cnt[i] != TO_C) stall_cnt[i] <= stall_cnt[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_out <= '0;
      rd_out <= '0;
    end else begin
      if (wr_inc && wr_out != MAX_C)    wr_out <= wr_out + CW'(1);
      else if (wr_dec && wr_out != '0)  wr_out <= wr_out - CW'(1);
      if (rd_inc && rd_out != MAX_C)    rd_out <= rd_out + CW'(1);
      else if (rd_dec && rd_out != '0)  rd_out <= rd_out - CW'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      err_flags     <= '0;
      err_first     <= '0;
      err_first_vld <= 1'b0;
      irq           <= 1'b0;
    end else begin
      err_flags <= flags_nxt;
      irq       <= |flags_nxt;
      if (err_clear) begin
        err_first     <= (|err_new) ? lowest(err_new) : 3'd0;
        err_first_vld <= |err_new;
      end else if (!err_first_vld && (|err_new)) begin
        err_first     <= lowest(err_new);
        err_first_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_protocol_monitor.sv
// Directed bench for axil_protocol_monitor with hand-computed expectations (MAX_OUT=4, TIMEOUT=16).
module tb_axil_protocol_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, err_clear;
  logic [7:0]  err_flags;
  logic [2:0]  err_first;
  logic        err_first_vld, irq;
  logic [2:0]  wr_out, rd_out;

  int n_chk = 0;
  int n_fail = 0;

  axil_protocol_monitor #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .TIMEOUT(16)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .err_clear(err_clear), .err_flags(err_flags), .err_first(err_first),
    .err_first_vld(err_first_vld), .irq(irq), .wr_out(wr_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; err_clear = 0;
  endtask

  task automatic clear_errs();
    idle();
    err_clear = 1;
    step();
    err_clear = 0;
  endtask

  initial begin
    awaddr = 0; wdata = 0; araddr = 0; rdata = 0; wstrb = 0; bresp = 0; rresp = 0;
    idle();
    #12;
    check("rst_flags", {24'd0, err_flags}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_first_vld", {31'd0, err_first_vld}, 32'h0);
    check("rst_wr_out", {29'd0, wr_out}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // AW address changes while stalled
    awvalid = 1; awready = 0; awaddr = 32'h10;
    step();
    check("aw_stall_ok", {24'd0, err_flags}, 32'h0);
    awaddr = 32'h14;
    step();
    check("aw_flags", {24'd0, err_flags}, 32'h01);
    check("aw_first", {29'd0, err_first}, 32'd0);
    check("aw_first_vld", {31'd0, err_first_vld}, 32'h1);
    check("aw_irq", {31'd0, irq}, 32'h1);
    idle(); step();
    clear_errs();
    check("clr_flags", {24'd0, err_flags}, 32'h0);
    check("clr_vld", {31'd0, err_first_vld}, 32'h0);
    check("clr_irq", {31'd0, irq}, 32'h0);

    // Stable stall followed by a legal handshake and response
    awvalid = 1; awready = 0; awaddr = 32'h20;
    step(); step();
    awready = 1;
    step();
    idle(); step();
    check("legal_aw_flags", {24'd0, err_flags}, 32'h0);
    check("legal_wr_out1", {29'd0, wr_out}, 32'd1);
    bvalid = 1; bready = 1;
    step();
    idle(); step();
    check("legal_wr_out0", {29'd0, wr_out}, 32'd0);
    check("legal_b_flags", {24'd0, err_flags}, 32'h0);

    // Overflow past MAX_OUT, then drain
    awvalid = 1; awready = 1;
    for (int i = 0; i < 4; i++) begin
      awaddr = 32'h100 + 32'(i * 4);
      step();
    end
    check("ovf_wr_out4", {29'd0, wr_out}, 32'd4);
    check("ovf_no_err_yet", {24'd0, err_flags}, 32'h0);
    step();
    check("ovf_wr_sat", {29'd0, wr_out}, 32'd4);
    check("ovf_flags", {24'd0, err_flags}, 32'h20);
    check("ovf_first", {29'd0, err_first}, 32'd5);
    idle();
    bvalid = 1; bready = 1;
    for (int i = 0; i < 4; i++) step();
    idle(); step();
    check("drain_wr_out", {29'd0, wr_out}, 32'd0);
    check("drain_flags", {24'd0, err_flags}, 32'h20);
    clear_errs();

    // Simultaneous AW and B handshakes at wr_out==0 are not an underflow
    awvalid = 1; awready = 1; bvalid = 1; bready = 1;
    step();
    idle(); step();
    check("both_hs_wr_out", {29'd0, wr_out}, 32'd0);
    check("both_hs_flags", {24'd0, err_flags}, 32'h0);

    // R stall timeout with stable data
    arvalid = 1; arready = 1; araddr = 32'h40;
    step();
    idle();
    check("to_rd_out1", {29'd0, rd_out}, 32'd1);
    rvalid = 1; rready = 0; rdata = 32'hDEAD; rresp = 2'b00;
    for (int i = 0; i < 15; i++) step();
    check("to_before", {24'd0, err_flags}, 32'h0);
    step();
    check("to_hit", {24'd0, err_flags}, 32'h80);
    check("to_first", {29'd0, err_first}, 32'd7);
    step(); step();
    check("to_sat_no_r", {24'd0, err_flags}, 32'h80);
    rready = 1;
    step();
    idle(); step();
    check("to_rd_out0", {29'd0, rd_out}, 32'd0);
    check("to_after_hs", {24'd0, err_flags}, 32'h80);
    clear_errs();

    // B underflow coinciding with R drop
    rvalid = 1; rready = 0; rdata = 32'h1;
    step();
    rvalid = 0; bvalid = 1; bready = 1;
    step();
    check("both_err_flags", {24'd0, err_flags}, 32'h30);
    check("both_err_first", {29'd0, err_first}, 32'd4);
    idle(); step();
    clear_errs();

    // err_clear while W drops: only the new W error survives
    awvalid = 1; awready = 1; arvalid = 1; arready = 1;
    step();
    idle(); arvalid = 1; arready = 0;
    step();
    arvalid = 0; wvalid = 1; wready = 0; wdata = 32'hCAFE; wstrb = 4'hF;
    step();
    check("pre_clr_flags", {24'd0, err_flags}, 32'h08);
    wvalid = 0; err_clear = 1;
    step();
    err_clear = 0;
    check("clrw_flags", {24'd0, err_flags}, 32'h02);
    check("clrw_first", {29'd0, err_first}, 32'd1);
    check("clrw_vld", {31'd0, err_first_vld}, 32'h1);
    check("clrw_wr_out", {29'd0, wr_out}, 32'd1);
    check("clrw_rd_out", {29'd0, rd_out}, 32'd1);

    // Reset with transactions in flight
    awvalid = 1; awready = 1; arvalid = 1; arready = 1;
    step();
    arvalid = 0; arready = 0;
    step();
    idle();
    check("pre_rst_wr", {29'd0, wr_out}, 32'd3);
    check("pre_rst_rd", {29'd0, rd_out}, 32'd2);
    awvalid = 1; awready = 0; awaddr = 32'h55;
    step();
    #2 rst_n = 0;
    #1;
    check("arst_flags", {24'd0, err_flags}, 32'h0);
    check("arst_irq", {31'd0, irq}, 32'h0);
    check("arst_wr", {29'd0, wr_out}, 32'd0);
    check("arst_rd", {29'd0, rd_out}, 32'd0);
    check("arst_first_vld", {31'd0, err_first_vld}, 32'h0);
    awaddr = 32'h77;
    step();
    rst_n = 1;
    awvalid = 0;
    step();
    step();
    check("rel_flags", {24'd0, err_flags}, 32'h0);
    check("rel_irq", {31'd0, irq}, 32'h0);
    check("rel_wr", {29'd0, wr_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_protocol_monitor.md
AXIL_PROTOCOL_MONITOR -- requirements
Module: axil_protocol_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width; STRB_W = DATA_W/8.
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum outstanding transactions per direction (1..15).
REQ-004 SHALL have parameter TIMEOUT, default 1024, stall cycles before timeout error (2..65535).
REQ-005 SHALL have port s_axi_aclk, input, 1, sole clock.
REQ-006 SHALL have port s_axi_aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have inputs s_axi_awaddr[ADDR_W], s_axi_awvalid, s_axi_awready, s_axi_wdata[DATA_W], s_axi_wstrb[STRB_W], s_axi_wvalid, s_axi_wready, s_axi_bresp[2], s_axi_bvalid, s_axi_bready: observed write channels.
REQ-008 SHALL have inputs s_axi_araddr[ADDR_W], s_axi_arvalid, s_axi_arready, s_axi_rdata[DATA_W], s_axi_rresp[2], s_axi_rvalid, s_axi_rready: observed read channels.
REQ-009 SHALL have port err_clear, input, 1, synchronous clear of sticky error state.
REQ-010 SHALL have port err_flags, output, 8, sticky error bits (bit map REQ-014).
REQ-011 SHALL have ports err_first, output, 3, and err_first_vld, output, 1: index of first error since clear.
REQ-012 SHALL have port irq, output, 1, OR of err_flags.
REQ-013 SHALL have ports wr_out and rd_out, output, $clog2(MAX_OUT+1) each, outstanding counts.

Function
REQ-014 Bit map: 0 AW, 1 W, 2 B, 3 AR, 4 R handshake-stability violation; 5 write-count violation; 6 read-count violation; 7 timeout.
REQ-015 Handshake = valid & ready in same rising edge.
REQ-016 Per channel, register stalled = valid & !ready and payload each cycle; next cycle, if stalled was 1 and (valid==0 or payload differs) -> set channel bit.
REQ-017 Payloads: AW=awaddr, W={wdata,wstrb}, B=bresp, AR=araddr, R={rdata,rresp}.
REQ-018 Stalled registers reset to 0: no stability check in first cycle after reset release.
REQ-019 wr_out: +1 on AW handshake, -1 on B handshake, unchanged when both same cycle.
REQ-020 AW handshake without B handshake while wr_out==MAX_OUT -> set bit 5, wr_out saturates at MAX_OUT.
REQ-021 B handshake without AW handshake while wr_out==0 -> set bit 5, wr_out stays 0.
REQ-022 rd_out, bit 6: identical rules using AR and R handshakes.
REQ-023 Per channel 16-bit stall counter: increments while valid & !ready, clears to 0 otherwise; reaching TIMEOUT sets bit 7; counter saturates at TIMEOUT.
REQ-024 err_flags bits are sticky; cleared only by reset or err_clear.
REQ-025 err_clear with new error same cycle: new error bit is set, all others cleared; err_first loads the new error.
REQ-026 err_first loads when err_first_vld==0 and any error occurs; lowest-numbered bit wins on simultaneous errors; err_first_vld then sets and holds until clear.
REQ-027 err_clear SHALL NOT affect wr_out, rd_out, stall counters or stalled registers.
REQ-028 Error detection to err_flags/irq visible: 1 cycle (registered).
REQ-029 Monitor SHALL be passive: no outputs drive the AXI bus.

Reset
REQ-030 On s_axi_aresetn low, asynchronously: err_flags=0, err_first=0, err_first_vld=0, irq=0, wr_out=0, rd_out=0, all stall counters and stalled registers 0.
REQ-031 Reset mid-transaction discards outstanding counts; no error raised on release.

Verification
REQ-032 awvalid=1, awready=0, awaddr 0x10 then 0x14 next cycle -> err_flags=0x01, err_first=0, irq=1 one cycle later.
REQ-033 MAX_OUT=4: 5 AW handshakes, no B -> wr_out=4, err_flags[5]=1; then 4 B handshakes -> wr_out=0.
REQ-034 rvalid=1, rready=0 for TIMEOUT=16 cycles -> err_flags[7]=1 exactly when counter hits 16; rdata stable, bit 4 stays 0.
REQ-035 B handshake with wr_out=0 and R stability error same cycle -> err_flags=0x30, err_first=4.
REQ-036 err_clear pulse while W drop occurs -> err_flags=0x02, err_first=1, wr_out/rd_out unchanged.
REQ-037 Reset asserted with wr_out=3, rd_out=2 -> all outputs 0 immediately; no error after release.
